// File: rtl/riscv_pkg.sv
// Shared definitions for the fetch stage and the units that consume its output.
package riscv_pkg;

  // Canonical NOP: addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int unsigned DEFAULT_QDEPTH   = 2;

  // Fetch FSM state encoding
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } fetch_state_t;

  // One instruction queue entry: word plus the PC it was fetched from
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  localparam fetch_entry_t EMPTY_ENTRY = '{instr: NOP_INSTR, pc: 32'h0000_0000};

  // Major opcodes shared with decode and control
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // Force a byte address onto a word boundary
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory, redirect and decode-side signals of the fetch stage.
interface fetch_stage_if;

  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instruction;
  logic [31:0] pc_out;
  logic        instr_valid;
  logic        id_ready;

  // Fetch stage side
  modport master (
    output imem_req_valid,
    input  imem_req_ready,
    output imem_addr,
    input  imem_rsp_valid,
    input  imem_rsp_data,
    input  redirect,
    input  redirect_pc,
    output instruction,
    output pc_out,
    output instr_valid,
    input  id_ready
  );

  // Memory / execute / decode side
  modport slave (
    input  imem_req_valid,
    output imem_req_ready,
    input  imem_addr,
    output imem_rsp_valid,
    output imem_rsp_data,
    output redirect,
    output redirect_pc,
    input  instruction,
    input  pc_out,
    input  instr_valid,
    output id_ready
  );

endinterface

// File: rtl/fetch_queue.sv
// Two-entry shift FIFO of {instruction, pc}. The head is a register that
// drives the decode outputs directly; an empty queue presents a NOP at pc 0.
module fetch_queue
  import riscv_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  fetch_entry_t push_data,
  output fetch_entry_t head,
  output logic [1:0]   count,
  output logic [1:0]   count_next,
  output logic         valid
);

  fetch_entry_t head_r, head_next_s;
  fetch_entry_t tail_r, tail_next_s;
  logic [1:0]   count_r, count_next_s;
  logic         valid_r;
  logic         pop_s;
  logic         push_s;

  // Next-state of the two entries and the occupancy count
  always_comb begin
    head_next_s  = head_r;
    tail_next_s  = tail_r;
    count_next_s = count_r;
    pop_s        = pop && (count_r != 2'd0);
    // a full queue only accepts a new word when the head leaves in the same cycle
    push_s       = push && ((count_r != 2'd2) || pop_s);
    if (flush) begin
      head_next_s  = EMPTY_ENTRY;
      count_next_s = 2'd0;
    end else begin
      case ({push_s, pop_s})
        2'b10: begin
          if (count_r == 2'd0) begin
            head_next_s  = push_data;
            count_next_s = 2'd1;
          end else begin
            tail_next_s  = push_data;
            count_next_s = 2'd2;
          end
        end
        2'b01: begin
          if (count_r == 2'd2) begin
            head_next_s  = tail_r;
            count_next_s = 2'd1;
          end else begin
            head_next_s  = EMPTY_ENTRY;
            count_next_s = 2'd0;
          end
        end
        2'b11: begin
          if (count_r == 2'd2) begin
            head_next_s = tail_r;
            tail_next_s = push_data;
          end else begin
            head_next_s = push_data;
          end
        end
        default: begin
          head_next_s  = head_r;
          count_next_s = count_r;
        end
      endcase
    end
  end

  // Queue storage and registered valid flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_r  <= EMPTY_ENTRY;
      tail_r  <= EMPTY_ENTRY;
      count_r <= 2'd0;
      valid_r <= 1'b0;
    end else begin
      head_r  <= head_next_s;
      tail_r  <= tail_next_s;
      count_r <= count_next_s;
      valid_r <= (count_next_s != 2'd0);
    end
  end

  assign head       = head_r;
  assign count      = count_r;
  assign count_next = count_next_s;
  assign valid      = valid_r;

endmodule

// File: rtl/fetch_stage_chk.sv
// Protocol properties of the fetch stage, kept apart from the datapath.
module fetch_stage_chk (
  input logic        clk,
  input logic        rst_n,
  input logic        req_valid,
  input logic        req_ready,
  input logic [31:0] addr,
  input logic        redirect,
  input logic        push,
  input logic        pop,
  input logic [1:0]  count
);

  // A pending request holds valid and address unless a redirect retargets it
  a_req_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (req_valid && !req_ready && !redirect) |=> (req_valid && $stable(addr)));

  // Requested addresses are always word aligned
  a_addr_aligned: assert property (@(posedge clk) disable iff (!rst_n)
    req_valid |-> (addr[1:0] == 2'b00));

  // The issue rule keeps a full queue from ever seeing a plain push
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (count == 2'd2)));

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, keeps at most one request in flight to
// instruction memory and hands {instruction, pc} to decode through a
// two-entry queue. Redirects flush the queue and kill the in-flight word.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned QDEPTH   = DEFAULT_QDEPTH
) (
  input logic             clk,
  input logic             rst_n,
  fetch_stage_if.master   bus
);

  localparam logic [1:0] QDEPTH_L = 2'(QDEPTH);

  fetch_state_t state_r, state_next_s;
  logic [31:0]  pc_r, pc_next_s, pc_adv_s;
  logic [31:0]  fetch_pc_r, fetch_pc_next_s;
  logic         req_valid_r, req_valid_next_s;
  logic [31:0]  addr_r;
  logic         accept_s;
  logic         push_s;
  logic         pop_s;
  fetch_entry_t push_data_s;
  fetch_entry_t head_s;
  logic [1:0]   q_count_s;
  logic [1:0]   q_count_next_s;
  logic         q_valid_s;

  assign accept_s    = (state_r == REQ) && req_valid_r && bus.imem_req_ready;
  assign pop_s       = q_valid_s && bus.id_ready;
  assign push_data_s = '{instr: bus.imem_rsp_data, pc: fetch_pc_r};

  // FSM next state, PC update and enqueue decision; redirect overrides the PC
  always_comb begin
    state_next_s    = state_r;
    pc_adv_s        = pc_r;
    fetch_pc_next_s = fetch_pc_r;
    push_s          = 1'b0;
    case (state_r)
      IDLE: begin
        state_next_s = REQ;
      end
      REQ: begin
        if (accept_s) begin
          fetch_pc_next_s = pc_r;
          if (bus.redirect) begin
            // the old-address request is out; its word must be thrown away
            state_next_s = DROP;
          end else begin
            state_next_s = WAIT;
            pc_adv_s     = pc_r + 32'd4;
          end
        end else begin
          state_next_s = REQ;
        end
      end
      WAIT: begin
        if (bus.imem_rsp_valid) begin
          state_next_s = REQ;
          push_s       = !bus.redirect;
        end else if (bus.redirect) begin
          state_next_s = DROP;
        end else begin
          state_next_s = WAIT;
        end
      end
      DROP: begin
        if (bus.imem_rsp_valid) begin
          state_next_s = REQ;
        end else begin
          state_next_s = DROP;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase

    if (bus.redirect) begin
      pc_next_s = word_align(bus.redirect_pc);
    end else begin
      pc_next_s = pc_adv_s;
    end

    // nothing is outstanding in REQ, so only queue occupancy gates the request
    req_valid_next_s = (state_next_s == REQ) && (q_count_next_s < QDEPTH_L);
  end

  // FSM, PC and registered memory-request outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      pc_r        <= RESET_PC;
      fetch_pc_r  <= 32'h0000_0000;
      req_valid_r <= 1'b0;
      addr_r      <= 32'h0000_0000;
    end else begin
      state_r     <= state_next_s;
      pc_r        <= pc_next_s;
      fetch_pc_r  <= fetch_pc_next_s;
      req_valid_r <= req_valid_next_s;
      addr_r      <= pc_next_s;
    end
  end

  fetch_queue u_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (bus.redirect),
    .push       (push_s),
    .pop        (pop_s),
    .push_data  (push_data_s),
    .head       (head_s),
    .count      (q_count_s),
    .count_next (q_count_next_s),
    .valid      (q_valid_s)
  );

  fetch_stage_chk u_chk (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid_r),
    .req_ready (bus.imem_req_ready),
    .addr      (addr_r),
    .redirect  (bus.redirect),
    .push      (push_s),
    .pop       (pop_s),
    .count     (q_count_s)
  );

  assign bus.imem_req_valid = req_valid_r;
  assign bus.imem_addr      = addr_r;
  assign bus.instruction    = head_s.instr;
  assign bus.pc_out         = head_s.pc;
  assign bus.instr_valid    = q_valid_s;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a small latency-programmable memory.
module tb_fetch_stage;
  import riscv_pkg::*;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  int   mem_lat;

  logic        acc_q;
  logic [31:0] acc_addr;
  logic        pend;
  logic [31:0] pend_addr;
  int          cnt;

  fetch_stage_if bus();

  fetch_stage #(.RESET_PC(32'h0000_0000), .QDEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: two fixed words, everything else derived from the address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0000) return 32'h0050_0093;
    else if (a == 32'h0000_0004) return 32'h00a0_0113;
    else return {a[23:0], 8'h13};
  endfunction

  // Record each accepted request at the clock edge
  always @(posedge clk) begin
    acc_q    <= rst_n && bus.imem_req_valid && bus.imem_req_ready;
    acc_addr <= bus.imem_addr;
  end

  // Return the word mem_lat cycles after acceptance, one cycle wide
  always @(negedge clk) begin
    if (!rst_n) begin
      pend <= 1'b0;
      cnt <= 0;
      bus.imem_rsp_valid <= 1'b0;
    end else if (acc_q && mem_lat == 1) begin
      bus.imem_rsp_valid <= 1'b1;
      bus.imem_rsp_data <= mem_word(acc_addr);
      pend <= 1'b0;
    end else if (acc_q) begin
      pend <= 1'b1;
      pend_addr <= acc_addr;
      cnt <= mem_lat - 1;
      bus.imem_rsp_valid <= 1'b0;
    end else if (pend && cnt == 1) begin
      bus.imem_rsp_valid <= 1'b1;
      bus.imem_rsp_data <= mem_word(pend_addr);
      pend <= 1'b0;
    end else if (pend) begin
      cnt <= cnt - 1;
      bus.imem_rsp_valid <= 1'b0;
    end else begin
      bus.imem_rsp_valid <= 1'b0;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Leaves the bench in cycle 0: reset just released, next edge leaves IDLE
  task automatic do_reset(input logic ready, input logic idr);
    rst_n = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.imem_req_ready = ready;
    bus.id_ready = idr;
    mem_lat = 1;
    step(2);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset(1'b1, 1'b1);
    rst_n = 1'b0;
    step(1);
    checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL reset_instr_valid: got %b want 0", bus.instr_valid); end
    checks++; if (bus.instruction !== 32'h0000_0013) begin errors++; $display("FAIL reset_instruction: got %h want 00000013", bus.instruction); end
    checks++; if (bus.pc_out !== 32'h0) begin errors++; $display("FAIL reset_pc_out: got %h want 00000000", bus.pc_out); end
    checks++; if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b want 0", bus.imem_req_valid); end
    checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 00000000", bus.imem_addr); end
  endtask

  task automatic test_basic_latency();
    do_reset(1'b1, 1'b1);
    step(1); // cycle 1
    checks++; if (bus.imem_req_valid !== 1'b1) begin errors++; $display("FAIL basic_req1_valid: got %b want 1", bus.imem_req_valid); end
    checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL basic_req1_addr: got %h want 00000000", bus.imem_addr); end
    step(1); // cycle 2
    checks++; if (bus.imem_req_valid !== 1'b0 || bus.instr_valid !== 1'b0) begin errors++; $display("FAIL basic_c2: got req=%b iv=%b want 0 0", bus.imem_req_valid, bus.instr_valid); end
    step(1); // cycle 3
    checks++; if (bus.instr_valid !== 1'b1) begin errors++; $display("FAIL basic_c3_valid: got %b want 1", bus.instr_valid); end
    checks++; if (bus.pc_out !== 32'h0) begin errors++; $display("FAIL basic_c3_pc: got %h want 00000000", bus.pc_out); end
    checks++; if (bus.instruction !== 32'h0050_0093) begin errors++; $display("FAIL basic_c3_instr: got %h want 00500093", bus.instruction); end
    checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_addr !== 32'h4) begin errors++; $display("FAIL basic_req2: got v=%b a=%h want 1 00000004", bus.imem_req_valid, bus.imem_addr); end
    step(1); // cycle 4
    checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL basic_c4_valid: got %b want 0", bus.instr_valid); end
    step(1); // cycle 5
    checks++; if (bus.instr_valid !== 1'b1 || bus.pc_out !== 32'h4) begin errors++; $display("FAIL basic_c5_pc: got v=%b pc=%h want 1 00000004", bus.instr_valid, bus.pc_out); end
    checks++; if (bus.instruction !== 32'h00a0_0113) begin errors++; $display("FAIL basic_c5_instr: got %h want 00a00113", bus.instruction); end
  endtask

  task automatic test_backpressure();
    do_reset(1'b1, 1'b0);
    step(5); // cycle 5: queue holds pc 0 and pc 4
    for (int i = 0; i < 5; i++) begin
      checks++; if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_req_idle[%0d]: got %b want 0", i, bus.imem_req_valid); end
      checks++; if (bus.instr_valid !== 1'b1 || bus.pc_out !== 32'h0) begin errors++; $display("FAIL bp_head[%0d]: got v=%b pc=%h want 1 00000000", i, bus.instr_valid, bus.pc_out); end
      step(1);
    end
    bus.id_ready = 1'b1; // cycle 10
    checks++; if (bus.instruction !== 32'h0050_0093) begin errors++; $display("FAIL bp_first_instr: got %h want 00500093", bus.instruction); end
    step(1); // cycle 11
    checks++; if (bus.instr_valid !== 1'b1 || bus.pc_out !== 32'h4 || bus.instruction !== 32'h00a0_0113) begin errors++; $display("FAIL bp_second: got v=%b pc=%h i=%h want 1 00000004 00a00113", bus.instr_valid, bus.pc_out, bus.instruction); end
    checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_addr !== 32'h8) begin errors++; $display("FAIL bp_resume_req: got v=%b a=%h want 1 00000008", bus.imem_req_valid, bus.imem_addr); end
    step(1); // cycle 12
    checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL bp_no_dup: got %b want 0", bus.instr_valid); end
    step(1); // cycle 13
    checks++; if (bus.pc_out !== 32'h8 || bus.instruction !== 32'h0000_0813) begin errors++; $display("FAIL bp_third: got pc=%h i=%h want 00000008 00000813", bus.pc_out, bus.instruction); end
  endtask

  task automatic test_redirect_wait();
    do_reset(1'b1, 1'b1);
    step(5); // cycle 5: request for 0x8 is being accepted
    mem_lat = 4;
    step(1); // cycle 6: waiting on 0x8
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h0000_0100;
    step(1); // cycle 7
    bus.redirect = 1'b0;
    mem_lat = 1;
    checks++; if (bus.imem_req_valid !== 1'b0 || bus.instr_valid !== 1'b0) begin errors++; $display("FAIL rw_c7: got req=%b iv=%b want 0 0", bus.imem_req_valid, bus.instr_valid); end
    step(1); // cycle 8
    checks++; if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL rw_drop_hold: got %b want 0", bus.imem_req_valid); end
    step(2); // cycle 10: stale word dropped in cycle 9
    checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_addr !== 32'h100) begin errors++; $display("FAIL rw_new_req: got v=%b a=%h want 1 00000100", bus.imem_req_valid, bus.imem_addr); end
    checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL rw_stale_dropped: got %b want 0", bus.instr_valid); end
    step(2); // cycle 12
    checks++; if (bus.instr_valid !== 1'b1 || bus.pc_out !== 32'h100 || bus.instruction !== 32'h0001_0013) begin errors++; $display("FAIL rw_target: got v=%b pc=%h i=%h want 1 00000100 00010013", bus.instr_valid, bus.pc_out, bus.instruction); end
  endtask

  task automatic test_redirect_rsp();
    do_reset(1'b1, 1'b0);
    step(4); // cycle 4: response for 0x4 present, queue holds pc 0
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h0000_0203;
    step(1); // cycle 5
    bus.redirect = 1'b0;
    bus.id_ready = 1'b1;
    checks++; if (bus.instr_valid !== 1'b0 || bus.instruction !== 32'h0000_0013) begin errors++; $display("FAIL rr_flushed: got v=%b i=%h want 0 00000013", bus.instr_valid, bus.instruction); end
    checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_addr !== 32'h200) begin errors++; $display("FAIL rr_req: got v=%b a=%h want 1 00000200", bus.imem_req_valid, bus.imem_addr); end
    step(2); // cycle 7
    checks++; if (bus.instr_valid !== 1'b1 || bus.pc_out !== 32'h200 || bus.instruction !== 32'h0002_0013) begin errors++; $display("FAIL rr_target: got v=%b pc=%h i=%h want 1 00000200 00020013", bus.instr_valid, bus.pc_out, bus.instruction); end
  endtask

  task automatic test_redirect_accept();
    do_reset(1'b1, 1'b1);
    step(1); // cycle 1: request for 0x0 accepted together with redirect
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h0000_0080;
    step(1); // cycle 2
    bus.redirect = 1'b0;
    checks++; if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL ra_drop: got %b want 0", bus.imem_req_valid); end
    step(1); // cycle 3
    checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_addr !== 32'h80 || bus.instr_valid !== 1'b0) begin errors++; $display("FAIL ra_req: got v=%b a=%h iv=%b want 1 00000080 0", bus.imem_req_valid, bus.imem_addr, bus.instr_valid); end
    step(2); // cycle 5
    checks++; if (bus.pc_out !== 32'h80 || bus.instruction !== 32'h0000_8013) begin errors++; $display("FAIL ra_target: got pc=%h i=%h want 00000080 00008013", bus.pc_out, bus.instruction); end
  endtask

  task automatic test_req_stall();
    do_reset(1'b0, 1'b1);
    step(1); // cycle 1
    for (int i = 0; i < 5; i++) begin
      checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_addr !== 32'h0) begin errors++; $display("FAIL stall_hold[%0d]: got v=%b a=%h want 1 00000000", i, bus.imem_req_valid, bus.imem_addr); end
      if (i < 4) step(1);
    end
    bus.redirect = 1'b1; // cycle 5, still not ready
    bus.redirect_pc = 32'h0000_0040;
    step(1); // cycle 6
    bus.redirect = 1'b0;
    checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_addr !== 32'h40) begin errors++; $display("FAIL stall_retarget: got v=%b a=%h want 1 00000040", bus.imem_req_valid, bus.imem_addr); end
    bus.imem_req_ready = 1'b1;
    step(2); // cycle 8
    checks++; if (bus.instr_valid !== 1'b1 || bus.pc_out !== 32'h40 || bus.instruction !== 32'h0000_4013) begin errors++; $display("FAIL stall_target: got v=%b pc=%h i=%h want 1 00000040 00004013", bus.instr_valid, bus.pc_out, bus.instruction); end
  endtask

  task automatic test_pc_wrap();
    do_reset(1'b0, 1'b1);
    step(1); // cycle 1
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFF;
    step(1); // cycle 2
    bus.redirect = 1'b0;
    checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_top_req: got v=%b a=%h want 1 fffffffc", bus.imem_req_valid, bus.imem_addr); end
    bus.imem_req_ready = 1'b1;
    step(2); // cycle 4
    checks++; if (bus.pc_out !== 32'hFFFF_FFFC || bus.instruction !== 32'hFFFF_FC13) begin errors++; $display("FAIL wrap_top_instr: got pc=%h i=%h want fffffffc fffffc13", bus.pc_out, bus.instruction); end
    checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_zero_req: got v=%b a=%h want 1 00000000", bus.imem_req_valid, bus.imem_addr); end
  endtask

  task automatic test_reset_mid_wait();
    do_reset(1'b1, 1'b0);
    step(3); // cycle 3: request for 0x4 being accepted
    mem_lat = 3;
    step(1); // cycle 4: waiting, queue holds pc 0
    checks++; if (bus.instr_valid !== 1'b1) begin errors++; $display("FAIL rm_pre_valid: got %b want 1", bus.instr_valid); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.instr_valid !== 1'b0 || bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL rm_async_valids: got iv=%b rv=%b want 0 0", bus.instr_valid, bus.imem_req_valid); end
    checks++; if (bus.instruction !== 32'h0000_0013 || bus.pc_out !== 32'h0 || bus.imem_addr !== 32'h0) begin errors++; $display("FAIL rm_async_data: got i=%h pc=%h a=%h want 00000013 00000000 00000000", bus.instruction, bus.pc_out, bus.imem_addr); end
    step(2);
    mem_lat = 1;
    bus.id_ready = 1'b1;
    rst_n = 1'b1; // cycle 0
    step(1);
    checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_addr !== 32'h0) begin errors++; $display("FAIL rm_restart_req: got v=%b a=%h want 1 00000000", bus.imem_req_valid, bus.imem_addr); end
    step(2); // cycle 3
    checks++; if (bus.instr_valid !== 1'b1 || bus.pc_out !== 32'h0 || bus.instruction !== 32'h0050_0093) begin errors++; $display("FAIL rm_restart_instr: got v=%b pc=%h i=%h want 1 00000000 00500093", bus.instr_valid, bus.pc_out, bus.instruction); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    mem_lat = 1;
    bus.imem_req_ready = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.id_ready = 1'b0;
    test_reset();
    test_basic_latency();
    test_backpressure();
    test_redirect_wait();
    test_redirect_rsp();
    test_redirect_accept();
    test_req_stall();
    test_pc_wrap();
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time limit so the run always ends
  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached with %0d checks done", checks);
    $fatal(1);
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage. It is the producer end of the instruction interface that the decode stage consumes.
- Owns the PC and issues word reads to instruction memory over a valid/ready request / valid response interface.
- Buffers returned words in a 2-entry queue and presents {instruction, pc} to decode with a valid/ready handshake.
- Handles branch redirects from execute: flushes the queue and discards any in-flight response.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- QDEPTH, 2, instruction queue depth (fixed at 2 for this revision).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request this cycle
- imem_addr  out  32  word address of request, bits[1:0]=0
- imem_rsp_valid  in  1  response data valid (exactly one per accepted request, ≥1 cycle after accept)
- imem_rsp_data  in  32  returned instruction word
- redirect  in  1  branch/jump taken, pulse
- redirect_pc  in  32  new PC; bits[1:0] ignored (forced 0)
- instruction  out  32  instruction to decode
- pc_out  out  32  PC of that instruction
- instr_valid  out  1  instruction/pc_out valid
- id_ready  in  1  decode accepts this cycle

Behaviour:
- Reset (async assert, sync-release effect):
  - pc=RESET_PC, state=IDLE, queue empty.
  - instr_valid=0, instruction=32'h0000_0013 (NOP), pc_out=0, imem_req_valid=0, imem_addr=0.
- At most one outstanding memory request.
- Request issue condition: queue count + outstanding < 2.
- FSM states:
  - IDLE: one cycle after reset release, then REQ.
  - REQ: imem_req_valid=1, imem_addr=pc; valid and addr are held stable until accepted.
    - On req_ready: fetch_pc<=pc, pc<=pc+4, go to WAIT.
    - Wait in REQ only while the issue condition holds; otherwise deassert valid, remain in REQ.
  - WAIT: on rsp_valid, enqueue {rsp_data, fetch_pc}, then go to REQ.
  - DROP: on rsp_valid, discard the data and go to REQ.
- Redirect (highest priority, applied in the same cycle as asserted):
  - pc<={redirect_pc[31:2],2'b00}; queue cleared; instr_valid=0 next cycle.
  - In REQ with req_ready same cycle: the request is considered accepted at the old address; go to DROP and do not advance pc past the target.
  - In WAIT without rsp_valid: go to DROP.
  - In WAIT with rsp_valid same cycle: response discarded; go to REQ.
  - In DROP: pc updated; remain in DROP.
  - In REQ without req_ready: imem_addr switches to the new pc next cycle. A valid request is allowed to change address only on redirect.
  - Simultaneous with decode handshake: redirect wins; the dequeued instruction is still considered consumed by decode.
- Queue:
  - Head is registered and drives instruction/pc_out directly; instr_valid = count != 0.
  - Dequeue when instr_valid && id_ready.
  - Enqueue and dequeue in the same cycle keeps count unchanged.
  - Enqueue into a full queue is impossible by the issue rule. The verifier asserts this never happens.
  - When empty, instruction holds the NOP pattern.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 wraps to 0.
- Latency, with memory rsp one cycle after accept and no stall:
  - Reset release at cycle 0 → request at cycle 1 → rsp at cycle 2 → instr_valid at cycle 3.
  - Steady throughput: 1 instruction per 2 cycles.
- Reset mid-operation: all state cleared immediately. Any response arriving after reset is ignored unless the FSM is in WAIT/DROP.

Decomposition:
- Package riscv_pkg holds:
  - NOP_INSTR = 32'h0000_0013.
  - Default RESET_PC.
  - FSM state enum {IDLE, REQ, WAIT, DROP} (2-bit).
  - Opcode constants shared with the decoder/control unit.
- Sub-module fetch_queue: 2-entry 64-bit FIFO with synchronous flush, push/pop/count/head outputs, async active-low reset.

Test Plan:
- Reset with RESET_PC=0; memory returns 0x00500093, 0x00a00113 at 0x0 and 0x4 with 1-cycle latency; id_ready=1 → instr_valid at cycle 3 with pc_out=0x0, then pc_out=0x4, instruction values match.
- id_ready=0 for 10 cycles → queue fills to 2 (pc 0x0, 0x4); imem_req_valid stays 0; on release both instructions are delivered in order with no loss or duplication.
- Redirect to 0x100 while in WAIT for 0x8, with the response arriving 3 cycles later → that response is dropped; next request addr=0x100; next delivered pc_out=0x100.
- Redirect to 0x203 in the same cycle as rsp_valid → data discarded, imem_addr=0x200, queue empty the following cycle.
- imem_req_ready held low 5 cycles → imem_addr/imem_req_valid stable throughout; a redirect to 0x40 during the hold changes imem_addr to 0x40 next cycle.
- PC at 0xFFFF_FFFC → next request addr=0x0; rst_n asserted mid-WAIT → all outputs at reset values asynchronously, fetch restarts at RESET_PC.
